// File: rtl/pipe_field_scroller.sv
// rtl/pipe_field_scroller.sv - scrolling COLS x ROWS pipe playfield with spawn port, spacing and pass scoring
// Optional step speed-up with score is compiled in by defining PIPE_FIELD_SPEEDUP_EN.
module pipe_field_scroller #(
  parameter int ROWS            = 16,
  parameter int COLS            = 16,
  parameter int STEP_CYCLES     = 8,
  parameter int MIN_STEP_CYCLES = 2,
  parameter int PIPE_SPACING    = 4,
  parameter int BIRD_COL        = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       gameover,
  input  logic                       spawn_valid,
  input  logic [ROWS-1:0]            spawn_col,
  output logic                       spawn_ready,
  output logic [COLS-1:0][ROWS-1:0]  field,
  output logic                       step,
  output logic                       pass_pulse,
  output logic [7:0]                 score,
  output logic                       running
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam int GW = $clog2(PIPE_SPACING + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(PIPE_SPACING - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FROZEN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] step_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] period;
  logic [CW-1:0] period_m1;
  logic          accept;

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [31:0] dec;
  always_comb begin
    dec = {26'd0, score[7:2]};
    if (dec + 32'(MIN_STEP_CYCLES) >= 32'(STEP_CYCLES))
      period = CW'(MIN_STEP_CYCLES);
    else
      period = CW'(32'(STEP_CYCLES) - dec);
  end
`else
  assign period = CW'(STEP_CYCLES);
`endif

  assign period_m1   = period - CW'(1);
  assign running     = (state == S_RUN);
  // gameover on the step cycle suppresses the step entirely
  assign step        = running && (step_cnt == period_m1) && !gameover;
  assign spawn_ready = step && (gap_cnt >= GAP_MAX);
  assign accept      = spawn_ready && spawn_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start)    state_next = S_RUN;
      S_RUN:    if (gameover) state_next = S_FROZEN;
      S_FROZEN: if (start)    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field      <= '0;
      score      <= '0;
      pass_pulse <= 1'b0;
      step_cnt   <= '0;
      gap_cnt    <= GAP_MAX;
    end else begin
      pass_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            step_cnt <= '0;
            gap_cnt  <= GAP_MAX;
          end
        end
        S_RUN: begin
          if (step) begin
            step_cnt <= '0;
            for (int c = 1; c < COLS; c++) field[c] <= field[c-1];
            field[0] <= accept ? spawn_col : '0;
            if (accept)
              gap_cnt <= '0;
            else if (gap_cnt < GAP_MAX)
              gap_cnt <= gap_cnt + GW'(1);
            if (field[BIRD_COL] != '0) begin
              pass_pulse <= 1'b1;
              if (score != 8'hFF) score <= score + 8'd1;
            end
          end else if (!gameover) begin
            // a shortened period can leave the counter past the new end; fire next cycle
            if (step_cnt > period_m1) step_cnt <= period_m1;
            else                      step_cnt <= step_cnt + CW'(1);
          end
        end
        S_FROZEN: begin
          if (start) begin
            field    <= '0;
            score    <= '0;
            step_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
